// File: rtl/ysyx_24100012_ifu_pkg.sv
// Shared types and constants for the ysyx_24100012 instruction fetch unit.
// Includes the fetch FSM state encoding and the fault-path NOP word.
package ysyx_24100012_ifu_pkg;

    typedef enum logic [2:0] {
        S_BOOT    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT_R  = 3'd2,
        S_OUT     = 3'd3,
        S_WAIT_PC = 3'd4
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    localparam int unsigned PERF_CNT_WIDTH = 32;

endpackage

// File: rtl/ysyx_24100012_perf_counter.sv
// 32-bit wrapping event counter with enable and async active-low reset.
// Shared by the IFU and other performance counters.
module ysyx_24100012_perf_counter
    import ysyx_24100012_ifu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    output logic [PERF_CNT_WIDTH-1:0] count
);

    logic [PERF_CNT_WIDTH-1:0] count_q;
    logic [PERF_CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + PERF_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ysyx_24100012_ifu.sv
// Instruction fetch unit: one outstanding AR/R read per instruction, then waits for write-back NPC.
// Optional access-fault reporting is enabled by defining YSYX_24100012_IFU_FAULT_EN.
module ysyx_24100012_ifu
    import ysyx_24100012_ifu_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] ifu_araddr,
    output logic                  ifu_arvalid,
    input  logic                  ifu_arready,
    input  logic [DATA_WIDTH-1:0] ifu_rdata,
    input  logic [1:0]            ifu_rresp,
    input  logic                  ifu_rvalid,
    output logic                  ifu_rready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic                  inst_fault,
    input  logic                  pc_update_valid,
    input  logic [ADDR_WIDTH-1:0] pc_next,
    output logic [31:0]           fetch_count
);

    ifu_state_e            state_q;
    ifu_state_e            state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] inst_q;
    logic [DATA_WIDTH-1:0] inst_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q;
    logic [ADDR_WIDTH-1:0] inst_pc_d;
    logic                  deliver;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        unique case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (ifu_arready) begin
                    state_d = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                if (ifu_rvalid) begin
                    state_d   = S_OUT;
                    inst_pc_d = pc_q;
`ifdef YSYX_24100012_IFU_FAULT_EN
                    if (ifu_rresp != RESP_OKAY) begin
                        inst_d = DATA_WIDTH'(NOP_INST);
                    end else begin
                        inst_d = ifu_rdata;
                    end
`else
                    inst_d = ifu_rdata;
`endif
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    state_d = S_WAIT_PC;
                end
            end
            S_WAIT_PC: begin
                // pc_next low bits are kept; only the fetch address is aligned
                if (pc_update_valid) begin
                    pc_d    = pc_next;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

`ifdef YSYX_24100012_IFU_FAULT_EN
    logic fault_q;
    logic fault_d;

    always_comb begin
        fault_d = fault_q;
        if (state_q == S_WAIT_R && ifu_rvalid) begin
            fault_d = (ifu_rresp != RESP_OKAY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign inst_fault = fault_q;
`else
    logic unused_rresp;

    assign unused_rresp = ^ifu_rresp;
    assign inst_fault   = 1'b0;
`endif

    assign ifu_araddr  = {pc_q[ADDR_WIDTH-1:2], 2'b00};
    assign ifu_arvalid = (state_q == S_REQ);
    assign ifu_rready  = (state_q == S_WAIT_R);
    assign inst_valid  = (state_q == S_OUT);
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign deliver     = inst_valid & inst_ready;

    ysyx_24100012_perf_counter u_fetch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (deliver),
        .count (fetch_count)
    );

endmodule

// File: tb/tb_ysyx_24100012_ifu.sv
// Self-checking bench for ysyx_24100012_ifu: directed scenarios plus randomized traffic.
// The reference model tracks completed handshakes per channel rather than FSM states.
module tb_ysyx_24100012_ifu;

    logic        clk;
    logic        rst_n;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        inst_fault;
    logic        pc_update_valid;
    logic [31:0] pc_next;
    logic [31:0] fetch_count;

    int n_pass  = 0;
    int n_total = 0;

    ysyx_24100012_ifu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ifu_araddr      (ifu_araddr),
        .ifu_arvalid     (ifu_arvalid),
        .ifu_arready     (ifu_arready),
        .ifu_rdata       (ifu_rdata),
        .ifu_rresp       (ifu_rresp),
        .ifu_rvalid      (ifu_rvalid),
        .ifu_rready      (ifu_rready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_fault      (inst_fault),
        .pc_update_valid (pc_update_valid),
        .pc_next         (pc_next),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: each channel's completed handshake count
    // determines which channel is currently owed a transfer.
    bit          m_booted;
    int unsigned m_ar, m_r, m_d, m_npc;
    logic [31:0] m_pc, m_inst, m_inst_pc;
    logic        m_fault;

    function automatic void reset_model();
        m_booted  = 1'b0;
        m_ar      = 0;
        m_r       = 0;
        m_d       = 0;
        m_npc     = 0;
        m_pc      = 32'h8000_0000;
        m_inst    = 32'h0;
        m_inst_pc = 32'h0;
        m_fault   = 1'b0;
    endfunction

    function automatic bit want_ar();
        return m_booted && (m_ar == m_npc);
    endfunction

    function automatic bit want_r();
        return m_r < m_ar;
    endfunction

    function automatic bit want_d();
        return m_d < m_r;
    endfunction

    function automatic bit want_npc();
        return m_booted && (m_npc < m_d);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        reset_model();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                reset_model();
            end else if (!m_booted) begin
                m_booted = 1'b1;
            end else begin
                bit a, r, d, n;
                a = want_ar();
                r = want_r();
                d = want_d();
                n = want_npc();
                if (a && ifu_arready) m_ar++;
                if (r && ifu_rvalid) begin
                    m_r++;
                    m_inst_pc = m_pc;
`ifdef YSYX_24100012_IFU_FAULT_EN
                    m_fault = (ifu_rresp != 2'b00);
                    m_inst  = m_fault ? 32'h0000_0013 : ifu_rdata;
`else
                    m_inst  = ifu_rdata;
`endif
                end
                if (d && inst_ready) m_d++;
                if (n && pc_update_valid) begin
                    m_npc++;
                    m_pc = pc_next;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("arvalid", ifu_arvalid, want_ar());
            chk("rready", ifu_rready, want_r());
            chk("inst_valid", inst_valid, want_d());
            chk("araddr", ifu_araddr, {m_pc[31:2], 2'b00});
            chk("inst", inst, m_inst);
            chk("inst_pc", inst_pc, m_inst_pc);
            chk("fetch_count", fetch_count, m_d);
            chk("inst_fault", inst_fault, m_fault);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        ifu_arready     = 1'b1;
        ifu_rvalid      = 1'b1;
        ifu_rdata       = 32'h0010_0513;
        ifu_rresp       = 2'b00;
        inst_ready      = 1'b1;
        pc_update_valid = 1'b0;
        pc_next         = 32'h0;
        repeat (3) tick();
        chk("rst_arvalid", ifu_arvalid, 0);
        chk("rst_count", fetch_count, 0);
        rst_n = 1'b1;

        // zero-wait first fetch: REQ, WAIT_R, OUT
        tick();
        chk("t1_arvalid", ifu_arvalid, 1);
        chk("t1_araddr", ifu_araddr, 32'h8000_0000);
        tick();
        chk("t1_rready", ifu_rready, 1);
        tick();
        chk("t1_valid", inst_valid, 1);
        chk("t1_inst", inst, 32'h0010_0513);
        chk("t1_pc", inst_pc, 32'h8000_0000);
        tick();
        chk("t1_count", fetch_count, 1);
        chk("t1_idle", inst_valid, 0);

        pc_update_valid = 1'b1;
        pc_next         = 32'h8000_0106;
        ifu_arready     = 1'b0;
        ifu_rvalid      = 1'b0;
        tick();
        pc_update_valid = 1'b0;

        // AR stall for 5 cycles
        for (int i = 0; i < 5; i++) begin
            chk("st_arvalid", ifu_arvalid, 1);
            chk("st_araddr", ifu_araddr, 32'h8000_0104);
            tick();
        end
        ifu_arready = 1'b1;
        tick();
        ifu_arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ifu_rdata = $urandom;
            chk("st_rready", ifu_rready, 1);
            chk("st_inst_hold", inst, 32'h0010_0513);
            tick();
        end
        ifu_rvalid = 1'b1;
        ifu_rdata  = 32'hDEAD_BEEF;
        inst_ready = 1'b0;
        tick();
        ifu_rvalid = 1'b0;
        chk("st_inst", inst, 32'hDEAD_BEEF);
        chk("st_pc", inst_pc, 32'h8000_0106);

        // decode backpressure with an ignored NPC pulse
        for (int i = 0; i < 4; i++) begin
            pc_update_valid = (i == 1);
            pc_next         = 32'h1234_5678;
            tick();
            chk("bp_valid", inst_valid, 1);
            chk("bp_inst", inst, 32'hDEAD_BEEF);
            chk("bp_count", fetch_count, 1);
        end
        pc_update_valid = 1'b0;
        inst_ready      = 1'b1;
        tick();
        chk("bp_count2", fetch_count, 2);
        chk("bp_pc_keep", ifu_araddr, 32'h8000_0104);
        pc_update_valid = 1'b1;
        pc_next         = 32'h8000_0200;
        ifu_arready     = 1'b1;
        tick();
        pc_update_valid = 1'b0;
        chk("npc2_araddr", ifu_araddr, 32'h8000_0200);

        // reset while a read is outstanding
        tick();
        chk("mr_rready", ifu_rready, 1);
        rst_n = 1'b0;
        reset_model();
        #1;
        chk("mr_rready0", ifu_rready, 0);
        chk("mr_inst0", inst, 0);
        chk("mr_pc0", inst_pc, 0);
        chk("mr_count0", fetch_count, 0);
        chk("mr_araddr", ifu_araddr, 32'h8000_0000);
        ifu_rvalid = 1'b1;
        ifu_rdata  = 32'h0020_0593;
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_refetch", ifu_araddr, 32'h8000_0000);
        chk("mr_arvalid", ifu_arvalid, 1);
        tick();
        tick();
        chk("mr_inst", inst, 32'h0020_0593);
        chk("mr_ipc", inst_pc, 32'h8000_0000);

        // error response, then an OKAY fetch
        tick();
        pc_update_valid = 1'b1;
        pc_next         = 32'h8000_0010;
        tick();
        pc_update_valid = 1'b0;
        ifu_rresp       = 2'b10;
        ifu_rdata       = 32'hCAFE_F00D;
        tick();
        tick();
`ifdef YSYX_24100012_IFU_FAULT_EN
        chk("ft_inst", inst, 32'h0000_0013);
        chk("ft_flag", inst_fault, 1);
`else
        chk("ft_inst", inst, 32'hCAFE_F00D);
        chk("ft_flag", inst_fault, 0);
`endif
        tick();
        pc_update_valid = 1'b1;
        pc_next         = 32'h8000_0014;
        tick();
        pc_update_valid = 1'b0;
        ifu_rresp       = 2'b00;
        ifu_rdata       = 32'h0000_0533;
        tick();
        tick();
        chk("ok_inst", inst, 32'h0000_0533);
        chk("ok_flag", inst_fault, 0);

        // randomized traffic checked every cycle by the model
        for (int c = 0; c < 4000; c++) begin
            ifu_arready     = ($urandom_range(0, 3) != 0);
            ifu_rvalid      = ($urandom_range(0, 2) != 0);
            ifu_rdata       = $urandom;
            ifu_rresp       = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            inst_ready      = ($urandom_range(0, 2) != 0);
            pc_update_valid = ($urandom_range(0, 2) == 0);
            pc_next         = $urandom;
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                reset_model();
                tick();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
